// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Attributes ID dependency stalls to scoreboard categories and dumps the counters as a stream.
// Optional VANILLA_SB_PROFILER_STREAK_EN adds a longest-stall-run counter as dump entry 6.
package vanilla_scoreboard_stall_profiler_pkg;
  localparam int RV32_reg_els_gp        = 32;
  localparam int RV32_reg_addr_width_gp = 5;

  typedef struct packed {
    logic idiv;
    logic remote_dram_load;
    logic remote_amo_dram;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_amo_group;
  } vanilla_isb_info_s;

  typedef struct packed {
    logic fdiv_fsqrt;
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
  } vanilla_fsb_info_s;
endpackage

module vanilla_scoreboard_stall_profiler
  import vanilla_scoreboard_stall_profiler_pkg::*;
#(
  parameter int ctr_width_p       = 32,
  parameter int reg_addr_width_lp = RV32_reg_addr_width_gp
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  vanilla_isb_info_s [RV32_reg_els_gp-1:0]       int_sb_i,
  input  vanilla_fsb_info_s [RV32_reg_els_gp-1:0]       float_sb_i,
  input  logic                                          stall_depend_i,
  input  logic                                          stall_all_i,
  input  logic [reg_addr_width_lp-1:0]                  rs1_i,
  input  logic [reg_addr_width_lp-1:0]                  rs2_i,
  input  logic [reg_addr_width_lp-1:0]                  rs3_i,
  input  logic [reg_addr_width_lp-1:0]                  rd_i,
  input  logic                                          read_rs1_i,
  input  logic                                          read_rs2_i,
  input  logic                                          write_rd_i,
  input  logic                                          read_frs1_i,
  input  logic                                          read_frs2_i,
  input  logic                                          read_frs3_i,
  input  logic                                          write_frd_i,
  input  logic                                          snapshot_v_i,
  input  logic                                          clear_on_snap_i,
  output logic                                          busy_o,
  output logic                                          v_o,
  input  logic                                          ready_i,
  output logic [2:0]                                    idx_o,
  output logic [ctr_width_p-1:0]                        data_o
);

  localparam int num_cat_lp = 6;
`ifdef VANILLA_SB_PROFILER_STREAK_EN
  localparam int num_ent_lp = 7;
`else
  localparam int num_ent_lp = 6;
`endif
  localparam logic [2:0] last_idx_lp = 3'(num_ent_lp - 1);
  localparam int isb_w_lp = $bits(vanilla_isb_info_s);
  localparam int fsb_w_lp = $bits(vanilla_fsb_info_s);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] v,
                                                     input logic en);
    if (en && (v != {ctr_width_p{1'b1}})) begin
      return v + ctr_width_p'(1);
    end else begin
      return v;
    end
  endfunction

  logic                     stall_q_s;
  logic                     use_rs1_s, use_rs2_s, use_rd_s;
  logic [isb_w_lp-1:0]      isb_or_s;
  logic [fsb_w_lp-1:0]      fsb_or_s;
  vanilla_isb_info_s        isb_hit_s;
  vanilla_fsb_info_s        fsb_hit_s;
  logic [num_cat_lp-1:0]    cat_hit_s, cat_sel_s, inc_s;

  logic [ctr_width_p-1:0]   cnt_r     [num_ent_lp];
  logic [ctr_width_p-1:0]   shadow_r  [num_ent_lp];
  logic [ctr_width_p-1:0]   cnt_nxt_s [num_ent_lp];
  logic [ctr_width_p-1:0]   cnt_clr_s [num_ent_lp];

  state_e                   state_r, state_nxt_s;
  logic [2:0]               idx_r, idx_nxt_s, idx_inc_s;
  logic [ctr_width_p-1:0]   data_r, data_nxt_s;
  logic                     snap_take_s;

  assign stall_q_s = stall_depend_i & ~stall_all_i;

  // Integer register 0 never carries a hazard.
  assign use_rs1_s = read_rs1_i & (rs1_i != '0);
  assign use_rs2_s = read_rs2_i & (rs2_i != '0);
  assign use_rd_s  = write_rd_i & (rd_i  != '0);

  assign isb_or_s = ({isb_w_lp{use_rs1_s}}   & int_sb_i[rs1_i])
                  | ({isb_w_lp{use_rs2_s}}   & int_sb_i[rs2_i])
                  | ({isb_w_lp{use_rd_s}}    & int_sb_i[rd_i]);
  assign fsb_or_s = ({fsb_w_lp{read_frs1_i}} & float_sb_i[rs1_i])
                  | ({fsb_w_lp{read_frs2_i}} & float_sb_i[rs2_i])
                  | ({fsb_w_lp{read_frs3_i}} & float_sb_i[rs3_i])
                  | ({fsb_w_lp{write_frd_i}} & float_sb_i[rd_i]);
  assign isb_hit_s = vanilla_isb_info_s'(isb_or_s);
  assign fsb_hit_s = vanilla_fsb_info_s'(fsb_or_s);

  assign cat_hit_s[0] = isb_hit_s.idiv;
  assign cat_hit_s[1] = fsb_hit_s.fdiv_fsqrt;
  assign cat_hit_s[2] = isb_hit_s.remote_dram_load | isb_hit_s.remote_amo_dram
                      | fsb_hit_s.remote_dram_load;
  assign cat_hit_s[3] = isb_hit_s.remote_global_load | fsb_hit_s.remote_global_load;
  assign cat_hit_s[4] = isb_hit_s.remote_group_load | isb_hit_s.remote_amo_group
                      | fsb_hit_s.remote_group_load;
  assign cat_hit_s[5] = ~|cat_hit_s[4:0];

  // Isolate the lowest set bit so the lowest category index wins.
  assign cat_sel_s = cat_hit_s & (~cat_hit_s + 6'd1);
  assign inc_s     = {num_cat_lp{stall_q_s}} & cat_sel_s;

`ifdef VANILLA_SB_PROFILER_STREAK_EN
  logic [ctr_width_p-1:0] run_r, run_nxt_s;

  assign run_nxt_s = stall_q_s ? sat_inc(run_r, 1'b1) : '0;

  // Current run length of back-to-back qualified stalls
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_r <= '0;
    end else if (snap_take_s && clear_on_snap_i) begin
      run_r <= ctr_width_p'(stall_q_s);
    end else begin
      run_r <= run_nxt_s;
    end
  end
`endif

  // Next-cycle counter values, with and without a clearing snapshot
  always_comb begin
    for (int i = 0; i < num_ent_lp; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      cnt_clr_s[i] = '0;
    end
    for (int i = 0; i < num_cat_lp; i++) begin
      cnt_nxt_s[i] = sat_inc(cnt_r[i], inc_s[i]);
      cnt_clr_s[i] = ctr_width_p'(inc_s[i]);
    end
`ifdef VANILLA_SB_PROFILER_STREAK_EN
    cnt_nxt_s[6] = (run_nxt_s > cnt_r[6]) ? run_nxt_s : cnt_r[6];
    cnt_clr_s[6] = ctr_width_p'(stall_q_s);
`endif
  end

  // Live counters and the shadow copy taken at snapshot
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_ent_lp; i++) begin
        cnt_r[i]    <= '0;
        shadow_r[i] <= '0;
      end
    end else if (snap_take_s) begin
      for (int i = 0; i < num_ent_lp; i++) begin
        shadow_r[i] <= cnt_nxt_s[i];
        cnt_r[i]    <= clear_on_snap_i ? cnt_clr_s[i] : cnt_nxt_s[i];
      end
    end else begin
      for (int i = 0; i < num_ent_lp; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign idx_inc_s = idx_r + 3'd1;

  // Dump FSM next state; data is precomputed so the output stays registered
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = data_r;
    snap_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (snapshot_v_i) begin
          snap_take_s = 1'b1;
          state_nxt_s = DRAIN;
          idx_nxt_s   = 3'd0;
          data_nxt_s  = cnt_nxt_s[0];
        end else begin
          idx_nxt_s  = 3'd0;
          data_nxt_s = '0;
        end
      end
      DRAIN: begin
        if (ready_i) begin
          if (idx_r == last_idx_lp) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = 3'd0;
            data_nxt_s  = '0;
          end else begin
            idx_nxt_s  = idx_inc_s;
            data_nxt_s = shadow_r[idx_inc_s];
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 3'd0;
        data_nxt_s  = '0;
      end
    endcase
  end

  // Dump FSM state and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign busy_o = (state_r == DRAIN);
  assign v_o    = (state_r == DRAIN);
  assign idx_o  = idx_r;
  assign data_o = data_r;

endmodule

// File: tb/tb_vanilla_scoreboard_stall_profiler.sv
// Scoreboard bench for vanilla_scoreboard_stall_profiler: directed stall scenarios, dumped entries
// are checked by a monitor against a queue of hand-computed expectations.
module tb_vanilla_scoreboard_stall_profiler;
  import vanilla_scoreboard_stall_profiler_pkg::*;

  localparam int W = 4;
`ifdef VANILLA_SB_PROFILER_STREAK_EN
  localparam int NENT = 7;
`else
  localparam int NENT = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vanilla_isb_info_s [RV32_reg_els_gp-1:0] int_sb;
  vanilla_fsb_info_s [RV32_reg_els_gp-1:0] float_sb;
  logic stall_depend, stall_all;
  logic [4:0] rs1, rs2, rs3, rd;
  logic read_rs1, read_rs2, write_rd, read_frs1, read_frs2, read_frs3, write_frd;
  logic snapshot_v, clear_on_snap, ready;
  logic busy_o, v_o;
  logic [2:0] idx_o;
  logic [W-1:0] data_o;

  typedef struct {int idx; int data;} exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  vanilla_scoreboard_stall_profiler #(.ctr_width_p(W)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .int_sb_i(int_sb), .float_sb_i(float_sb),
    .stall_depend_i(stall_depend), .stall_all_i(stall_all),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rd_i(rd),
    .read_rs1_i(read_rs1), .read_rs2_i(read_rs2), .write_rd_i(write_rd),
    .read_frs1_i(read_frs1), .read_frs2_i(read_frs2), .read_frs3_i(read_frs3),
    .write_frd_i(write_frd), .snapshot_v_i(snapshot_v), .clear_on_snap_i(clear_on_snap),
    .busy_o(busy_o), .v_o(v_o), .ready_i(ready), .idx_o(idx_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per accepted entry; idle outputs must read zero
  always @(negedge clk) begin
    if (rst_n) begin
      if (v_o && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", int'(idx_o), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("entry_idx", int'(idx_o), e.idx);
          chk($sformatf("entry%0d_data", e.idx), int'(data_o), e.data);
        end
      end else if (!v_o) begin
        chk("idle_idx", int'(idx_o), 0);
        chk("idle_data", int'(data_o), 0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    int_sb = '0; float_sb = '0;
    stall_depend = 1'b0; stall_all = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0; rd = 5'd0;
    read_rs1 = 1'b0; read_rs2 = 1'b0; write_rd = 1'b0;
    read_frs1 = 1'b0; read_frs2 = 1'b0; read_frs3 = 1'b0; write_frd = 1'b0;
  endtask

  task automatic stall_cycles(input int n);
    stall_depend = 1'b1;
    repeat (n) cycle();
    stall_depend = 1'b0;
  endtask

  task automatic push_exp(input int e[7]);
    for (int i = 0; i < NENT; i++) exp_q.push_back('{i, e[i]});
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 40 && busy_o; k++) cycle();
    chk({name, "_drain_done"}, int'(busy_o), 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic dump(input string name, input int e[7]);
    push_exp(e);
    snapshot_v = 1'b1; clear_on_snap = 1'b1; ready = 1'b1;
    cycle();
    chk({name, "_busy"}, int'(busy_o), 1);
    snapshot_v = 1'b0; clear_on_snap = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    clr_in();
    snapshot_v = 1'b0; clear_on_snap = 1'b0; ready = 1'b0;
    repeat (2) cycle();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_v", int'(v_o), 0);
    chk("rst_idx", int'(idx_o), 0);
    chk("rst_data", int'(data_o), 0);
    rst_n = 1'b1;
    cycle();

    // Integer divide dependency, 10 cycles
    int_sb[5].idiv = 1'b1; rs1 = 5'd5; read_rs1 = 1'b1;
    stall_cycles(10); clr_in();
    dump("t1", '{10, 0, 0, 0, 0, 0, 10});

    // fdiv outranks dram on the same float register
    float_sb[3].remote_dram_load = 1'b1; float_sb[3].fdiv_fsqrt = 1'b1;
    rs3 = 5'd3; read_frs3 = 1'b1;
    stall_cycles(4); clr_in();
    dump("t2", '{0, 4, 0, 0, 0, 0, 4});

    // Global stall masks counting; x0 never forms a hazard
    stall_all = 1'b1; stall_cycles(8); stall_all = 1'b0;
    int_sb[0].idiv = 1'b1; rs1 = 5'd0; read_rs1 = 1'b1;
    stall_cycles(3); clr_in();
    dump("t3", '{0, 0, 0, 0, 0, 3, 3});

    // Clearing snapshot with concurrent group stall, back-pressure, counting during drain
    ready = 1'b0;
    int_sb[7].remote_group_load = 1'b1; rs2 = 5'd7; read_rs2 = 1'b1; stall_depend = 1'b1;
    repeat (6) cycle();
    push_exp('{0, 0, 0, 0, 7, 0, 7});
    snapshot_v = 1'b1; clear_on_snap = 1'b1;
    cycle();
    chk("t4_busy", int'(busy_o), 1);
    clear_on_snap = 1'b0; clr_in();
    cycle();
    chk("t4_hold_a_idx", int'(idx_o), 0);
    chk("t4_hold_a_v", int'(v_o), 1);
    snapshot_v = 1'b0;
    int_sb[9].remote_amo_dram = 1'b1; rd = 5'd9; write_rd = 1'b1; stall_depend = 1'b1;
    cycle();
    chk("t4_hold_b_idx", int'(idx_o), 0);
    ready = 1'b1;
    cycle();
    chk("t4_advance_idx", int'(idx_o), 1);
    clr_in();
    wait_drain("t4");
    dump("t4_live", '{0, 0, 2, 0, 1, 0, 2});

    // Saturation at all-ones
    int_sb[4].remote_global_load = 1'b1; rs1 = 5'd4; read_rs1 = 1'b1;
    stall_cycles(15); stall_cycles(5); clr_in();
    dump("t5", '{0, 0, 0, 15, 0, 0, 15});

    // Reset in the middle of a dump
    int_sb[2].idiv = 1'b1; rs1 = 5'd2; read_rs1 = 1'b1;
    stall_cycles(3); clr_in();
    exp_q.push_back('{0, 3});
    exp_q.push_back('{1, 0});
    snapshot_v = 1'b1; clear_on_snap = 1'b0; ready = 1'b1;
    cycle();
    snapshot_v = 1'b0;
    for (int k = 0; k < 10 && idx_o != 3'd2; k++) cycle();
    chk("t6_reach_idx2", int'(idx_o), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", int'(v_o), 0);
    chk("t6_rst_busy", int'(busy_o), 0);
    chk("t6_rst_idx", int'(idx_o), 0);
    chk("t6_rst_data", int'(data_o), 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("t6_no_resume", int'(busy_o), 0);
    chk("t6_queue_empty", exp_q.size(), 0);
    dump("t6_post", '{0, 0, 0, 0, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vanilla_scoreboard_stall_profiler.md
VANILLA_SCOREBOARD_STALL_PROFILER -- requirements
Module: vanilla_scoreboard_stall_profiler

Interface
REQ-001 SHALL have parameter ctr_width_p, default 32: width of each stall counter and of data_o.
REQ-002 SHALL have parameter reg_addr_width_lp, default RV32_reg_addr_width_gp: register index width.
REQ-003 SHALL have ports, in order:
- clk_i  in  1  sole clock; all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- int_sb_i  in  RV32_reg_els_gp x vanilla_isb_info_s  integer scoreboard from tracker.
- float_sb_i  in  RV32_reg_els_gp x vanilla_fsb_info_s  float scoreboard from tracker.
- stall_depend_i  in  1  ID held on a data dependency this cycle.
- stall_all_i  in  1  global pipeline stall.
- rs1_i, rs2_i, rs3_i, rd_i  in  reg_addr_width_lp each  ID operand indices.
- read_rs1_i, read_rs2_i, write_rd_i  in  1 each  int operand use.
- read_frs1_i, read_frs2_i, read_frs3_i, write_frd_i  in  1 each  float operand use.
- snapshot_v_i  in  1  request counter dump.
- clear_on_snap_i  in  1  zero live counters when the snapshot is taken.
- busy_o  out  1  dump in progress.
- v_o  out  1  dump entry valid.
- ready_i  in  1  consumer accepts entry when v_o & ready_i.
- idx_o  out  3  category index of current entry.
- data_o  out  ctr_width_p  counter value of current entry.

Function
REQ-004 SHALL qualify a stall cycle as stall_depend_i & ~stall_all_i.
REQ-005 SHALL build a hazard set: int regs rs1/rs2 (if read), rd (if write_rd_i); float regs frs1/frs2/frs3 (if read), rd (if write_frd_i); int register 0 excluded.
REQ-006 SHALL OR scoreboard fields over the hazard set into categories: 0 idiv; 1 fdiv_fsqrt; 2 dram (int remote_dram_load|remote_amo_dram, float remote_dram_load); 3 global (remote_global_load); 4 group (int remote_group_load|remote_amo_group, float remote_group_load); 5 other (none set).
REQ-007 SHALL increment exactly one counter per qualified cycle, lowest set category index winning.
REQ-008 SHALL make increments visible one cycle after the qualifying edge.
REQ-009 SHALL saturate counters at all-ones; no wrap.
REQ-010 SHALL have states IDLE and DRAIN; busy_o = (state==DRAIN).
REQ-011 IDLE with snapshot_v_i at an edge: SHALL copy all counters (including that cycle's increment) into shadow registers, enter DRAIN, set idx_o=0.
REQ-012 If clear_on_snap_i is also high, live counters SHALL be zeroed at that edge, except a same-cycle qualified stall, which SHALL leave its counter at 1.
REQ-013 In DRAIN: v_o=1, data_o = shadow[idx_o]; on v_o & ready_i idx_o SHALL advance; after accepting the last entry, SHALL return to IDLE with idx_o=0.
REQ-014 v_o low: idx_o and data_o SHALL hold 0.
REQ-015 snapshot_v_i during DRAIN SHALL be ignored; no queuing.
REQ-016 Counting SHALL continue unaffected during DRAIN.

Reset
REQ-017 reset_n_i low SHALL asynchronously force IDLE, all counters/shadows 0, busy_o=0, v_o=0, idx_o=0, data_o=0.
REQ-018 Reset mid-DRAIN SHALL abort the dump; no further entries after release.

Configuration
REQ-019 VANILLA_SB_PROFILER_STREAK_EN defined: SHALL track the longest run of consecutive qualified cycles (saturating, cleared by clear_on_snap_i like counters) and drain it as entry 6; dump = 7 entries.
REQ-020 Macro undefined: no streak logic; dump = 6 entries (0..5).

Verification
REQ-021 int_sb_i[5].idiv=1, rs1_i=5, read_rs1_i=1, stall_depend_i high 10 cycles -> counter 0 = 10, others 0.
REQ-022 float_sb_i[3].remote_dram_load=1 and float_sb_i[3].fdiv_fsqrt=1, rs3_i=3, read_frs3_i=1, 4 stall cycles -> counter 1 = 4 (priority), counter 2 = 0.
REQ-023 stall_depend_i=1 with stall_all_i=1 for 8 cycles, then 3 cycles stall_depend_i only with rs1_i=0 flagged -> only counter 5 = 3.
REQ-024 Counter 4 = 7, snapshot with clear_on_snap_i=1 and concurrent group stall, ready_i low 2 cycles then high -> busy_o next cycle, entry 4 reads 7, live counter 4 = 1, back to IDLE after 6 (7 with streak) accepts.
REQ-025 Preload counter 3 to all-ones (ctr_width_p=4), 5 more global stalls -> stays 15.
REQ-026 reset_n_i low mid-DRAIN at idx_o=2 -> v_o, busy_o, idx_o immediately 0; snapshot after release dumps all zeros.
